// File: rtl/uart_defs_pkg.sv
// uart_defs_pkg: frame parameters, rx state encodings and baud divisor rounding shared by uart tx/rx
package uart_defs_pkg;
    localparam int OVERSAMPLE  = 16;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return (clk_freq + (OVERSAMPLE / 2) * baud_rate) / (OVERSAMPLE * baud_rate);
    endfunction
endpackage

// File: rtl/uart_rx_os_tick.sv
// uart_rx_os_tick: divisor counter emitting the 16x oversample tick
// Ports: clk, rst (sync, active high); i_clr restarts the phase; i_en runs the counter
// (held at 0 when low); o_tick pulses one cycle every DIV enabled clocks.
module uart_rx_os_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] r_cnt;
    logic          w_wrap;
    assign w_wrap = r_cnt == CW'(DIV - 1);
    assign o_tick = i_en & w_wrap;
    always_ff @(posedge clk) begin
        if (rst || i_clr || !i_en)
            r_cnt <= '0;
        else
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling asynchronous serial receiver with parity and framing checks
// Ports: clk, rst (sync, active high); rx raw idle-high line; data last word (held);
// data_valid one-cycle strobe; parity_err/frame_err qualified by data_valid;
// rx_busy high while a frame is being received.
module uart_rx
    import uart_defs_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_BIT = 0,
    parameter int DATA_LEN   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [DATA_LEN-1:0] data,
    output logic                data_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                rx_busy
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

    rx_state_t           r_state, w_next;
    logic                r_sync1, r_sync2, r_prev;
    logic [3:0]          r_sidx, r_bcnt;
    logic [DATA_LEN-1:0] r_shift;
    logic                r_s7, r_s8, r_perr;
    logic                w_tick, w_fall, w_bit, w_t9, w_t15, w_last, w_exp;

    assign w_fall  = r_prev & ~r_sync2;
    assign w_t9    = w_tick && r_sidx == 4'd9;
    assign w_t15   = w_tick && r_sidx == 4'd15;
    assign w_last  = r_bcnt == 4'(DATA_LEN - 1);
    // Majority of ticks 7, 8 and the live sample at tick 9.
    assign w_bit   = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
    assign w_exp   = PARITY_BIT == PARITY_ODD ? ~^r_shift : ^r_shift;
    assign rx_busy = r_state != RX_IDLE;

    uart_rx_os_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_fall && r_state == RX_IDLE),
        .i_en  (r_state != RX_IDLE),
        .o_tick(w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= RX_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:   w_next = w_fall ? RX_START : RX_IDLE;
            RX_START:  w_next = (w_t9 && w_bit) ? RX_IDLE : (w_t15 ? RX_DATA : RX_START);
            RX_DATA:   w_next = (w_t15 && w_last) ? (PARITY_BIT != PARITY_NONE ? RX_PARITY : RX_STOP) : RX_DATA;
            RX_PARITY: w_next = w_t15 ? RX_STOP : RX_PARITY;
            RX_STOP:   w_next = w_t9 ? RX_IDLE : RX_STOP;
            default:   w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_prev     <= 1'b1;
            r_sidx     <= '0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            r_s7       <= 1'b0;
            r_s8       <= 1'b0;
            r_perr     <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_sync1    <= rx;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            data_valid <= 1'b0;
            if (r_state == RX_IDLE) begin
                r_sidx <= '0;
                r_bcnt <= '0;
                r_perr <= 1'b0;
            end else if (w_tick)
                r_sidx <= r_sidx + 4'd1;
            if (w_tick && r_sidx == 4'd7)
                r_s7 <= r_sync2;
            if (w_tick && r_sidx == 4'd8)
                r_s8 <= r_sync2;
            // Right shift with the new bit at the MSB: first bit lands in bit 0.
            if (r_state == RX_DATA && w_t9)
                r_shift <= {w_bit, r_shift[DATA_LEN-1:1]};
            if (r_state == RX_DATA && w_t15)
                r_bcnt <= w_last ? 4'd0 : r_bcnt + 4'd1;
            if (r_state == RX_PARITY && w_t9)
                r_perr <= w_bit != w_exp;
            // Leave at mid-stop so any stop length is accepted with half a bit of resync margin.
            if (r_state == RX_STOP && w_t9) begin
                data       <= r_shift;
                frame_err  <= ~w_bit;
                parity_err <= r_perr;
                data_valid <= 1'b1;
            end
        end
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the counterpart of the transmit stage. It takes the raw line from the pin, oversamples it 16x, and deframes start, data, optional parity and stop bits. Each received word is presented as a parallel word with a one-cycle valid strobe and error flags. It sits between the board RX pin and any consumer logic, such as a FIFO or a command decoder, and uses the same frame parameters as the transmitter so that a tx/rx pair can loop back.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz
- BAUD_RATE, 9600: line rate in bit/s
- PARITY_BIT, 0: 0 = none, 1 = odd, 2 = even
- DATA_LEN, 8: data bits per frame, 5..9, sent LSB first

Ports:
- clk  in  1: system clock; the only clock
- rst  in  1: synchronous, active-high reset
- rx  in  1: raw serial line, asynchronous, idle high
- data  out  DATA_LEN: last received word, held until the next frame completes
- data_valid  out  1: one-cycle pulse, data and flags valid
- parity_err  out  1: parity mismatch for this word, qualified by data_valid
- frame_err  out  1: stop bit sampled low, qualified by data_valid
- rx_busy  out  1: high from the start-edge detect until the frame ends or is rejected

## Operation
- rx passes through a 2-flop synchronizer, reset value 1. A third flop holds the previous value for edge detect.
- Oversample tick: one-cycle pulse every DIV clocks, where DIV = (CLK_FREQ + 8*BAUD_RATE) / (16*BAUD_RATE), rounded to nearest.
  - The tick counter is cleared on start-edge detect, so sample phase is aligned to the edge.
  - The counter holds at 0 in IDLE.
- A 4-bit sample index, 0..15, counts ticks within a bit.
- Bit value = majority of the synchronized rx at ticks 7, 8 and 9. It is evaluated at tick 9.
- States:
  - IDLE: rx_busy = 0. A synchronized falling edge (prev = 1, cur = 0) goes to START.
  - START: at tick 9 of the bit, majority 1 → false start, back to IDLE with no strobe. Majority 0 → continue sampling to tick 15, then go to DATA.
  - DATA: at tick 9, shift the bit in at the MSB of the shift register, right-shift. After DATA_LEN bits (bit counter), at tick 15 go to PARITY if PARITY_BIT != 0, else go to STOP.
  - PARITY: at tick 9, compare the bit against the expected value. Expected = ~^shift for odd and ^shift for even, matching the transmit-side convention. Go to STOP at tick 15.
  - STOP: at tick 9, evaluate the stop bit. Load data from the shift register, set frame_err = ~stop, latch parity_err, pulse data_valid, and go to IDLE.
- Frames with an error are still delivered, with the flag set.
- Exit at mid-stop (tick 9) gives half a bit of resync margin. This makes 1, 1.5 and 2 stop bits from the transmitter all acceptable without a parameter.
- Break/low line after a frame error: no new start is accepted until rx has been seen high, because detection needs a falling edge.
- DATA_LEN < 9: the shift register is DATA_LEN wide. The first received bit ends in data[0].

## Timing
- Reset values: data = 0, data_valid = 0, parity_err = 0, frame_err = 0, rx_busy = 0, state = IDLE, synchronizer = 1.
- Reset mid-frame: the next cycle is IDLE, with no strobe and the partial word discarded.
- Edge-to-detect latency: 3 clk. From the pin to the edge registered in the state.
- rx_busy rises the cycle after edge detect.
- data_valid pulses exactly 1 clk, in the cycle after the tick-9 sample of the stop bit. rx_busy falls in the same cycle.
- data, parity_err and frame_err change only on that cycle. They are stable otherwise, including during the next frame.
- A falling edge in the same cycle as the return to IDLE is ignored. The next edge is accepted from the following cycle.
- The minimum accepted idle gap between frames is 0 bits; the start edge follows immediately.

## Structure
- Shared package/header (uart_defs):
  - parity encodings PARITY_NONE/ODD/EVEN
  - the DIV rounding expression
  - OVERSAMPLE = 16
  - the rx state encodings
  - the transmitter uses the same package
- One sub-module, uart_rx_os_tick:
  - divisor counter with a synchronous clear input and an enable input
  - emits the 16x tick
  - reusable for the transmitter later
- Synchronizer, FSM, bit counter and shift register are inline in uart_rx.

## Test plan
Bench at CLK_FREQ = 50_000_000, BAUD_RATE = 115200 (DIV = 27, 432 clk/bit), driving ideal frames.
1. PARITY_BIT = 0, send 0xA5 → single data_valid, data = 0xA5, both errs 0, rx_busy high ~9.5 bit times.
2. PARITY_BIT = 2, send 0x07 with parity 1 then parity 0 → first parity_err = 0, second parity_err = 1 with data = 0x07.
3. Stop bit driven 0 for 0x3C → data = 0x3C, frame_err = 1. Hold rx low 3 bit times, then raise it, then send 0x11 → exactly one further strobe, data = 0x11.
4. rx low glitch of 100 clk in IDLE → no data_valid, rx_busy returns to 0 before tick 10.
5. Back-to-back 0x55, 0xAA, 0xFF with 0 idle bits, and BAUD_RATE skewed ±3% → three strobes with correct data, no errors.
6. rst pulsed during bit 4 of a frame, then a clean 0x81 frame → no strobe for the aborted frame, then data = 0x81.
